// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer (TH reload, TL up-counter, TCON control/status) with a
// registered level interrupt that is masked while the CPU runs in kernel mode.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE  = 32'h4000_0000,
  parameter int          CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [CNT_W-1:0] th_q, th_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic             irq_q, irq_d;

  logic base_match, aligned;
  logic sel_th, sel_tl, sel_tcon;
  logic wr_th, wr_tl, wr_tcon;
  logic set_status;

  logic unused_pc;
  assign unused_pc = ^pc[30:0];

  assign base_match = (addr[31:4] == BASE[31:4]);
  assign aligned    = (addr[1:0] == 2'b00);
  assign sel_th     = base_match & aligned & (addr[3:2] == 2'd0);
  assign sel_tl     = base_match & aligned & (addr[3:2] == 2'd1);
  assign sel_tcon   = base_match & aligned & (addr[3:2] == 2'd2);
  assign hit        = sel_th | sel_tl | sel_tcon;

  assign wr_th      = mem_wr & sel_th;
  assign wr_tl      = mem_wr & sel_tl;
  assign wr_tcon    = mem_wr & sel_tcon;

  // Read path is purely combinational: the CPU completes a load in one cycle.
  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (sel_th)   rdata[CNT_W-1:0] = th_q;
      if (sel_tl)   rdata[CNT_W-1:0] = tl_q;
      if (sel_tcon) rdata[2:0]       = tcon_q;
    end
  end

  always_comb begin
    th_d       = th_q;
    tl_d       = tl_q;
    tcon_d     = tcon_q;
    set_status = 1'b0;

    if (wr_th) th_d = wdata[CNT_W-1:0];

    // A software TL write takes priority over both increment and reload;
    // the reload always uses the TH value held before this edge.
    if (wr_tl) begin
      tl_d = wdata[CNT_W-1:0];
    end else if (tcon_q[0]) begin
      if (tl_q == '1) begin
        tl_d       = th_q;
        set_status = tcon_q[1];
      end else begin
        tl_d = tl_q + 1'b1;
      end
    end

    if (wr_tcon)    tcon_d    = wdata[2:0];
    // Hardware set beats a simultaneous software clear so no interrupt is lost.
    if (set_status) tcon_d[2] = 1'b1;

    irq_d = tcon_q[2] & tcon_q[1] & ~pc[31];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= 3'b000;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
